// File: rtl/vga_pkg.sv
// Shared constants for the VGA drawing blocks: command modes, sequencer
// states and default screen geometry.
package vga_pkg;

  localparam logic [1:0] MODE_OUTLINE = 2'd0;
  localparam logic [1:0] MODE_FILLED  = 2'd1;
  localparam logic [1:0] MODE_CLEAR   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/raster_scan.sv
// 2-D raster counter: walks (cx, cy) row by row over a loaded width x height
// area, flagging the final pixel and pixels on the border.
module raster_scan #(
  parameter int CX_W = 8,
  parameter int CY_W = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [CX_W-1:0] width,
  input  logic [CY_W-1:0] height,
  input  logic            advance,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last,
  output logic            on_edge
);

  localparam logic [CX_W-1:0] ONE_X = CX_W'(1);
  localparam logic [CY_W-1:0] ONE_Y = CY_W'(1);

  logic [CX_W-1:0] w_q;
  logic [CY_W-1:0] h_q;
  logic            x_end;
  logic            y_end;

  assign x_end   = (cx == w_q - ONE_X);
  assign y_end   = (cy == h_q - ONE_Y);
  assign last    = x_end && y_end;
  assign on_edge = (cx == '0) || x_end || (cy == '0) || y_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cx  <= '0;
      cy  <= '0;
      w_q <= '0;
      h_q <= '0;
    end else if (load) begin
      cx  <= '0;
      cy  <= '0;
      w_q <= width;
      h_q <= height;
    end else if (advance) begin
      if (x_end) begin
        cx <= '0;
        cy <= cy + ONE_Y;
      end else begin
        cx <= cx + ONE_X;
      end
    end
  end

endmodule

// File: rtl/box_plotter.sv
// Rectangle/clear pixel sequencer feeding vga_adapter: one pixel per clock,
// w*h cycles per command regardless of mode or clipping, done pulse at end.
module box_plotter import vga_pkg::*; #(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = 3,
  parameter int SIZE_W   = 5,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [SIZE_W-1:0]   w_in,
  input  logic [SIZE_W-1:0]   h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  // Counters must hold a full-screen CLEAR, not just the largest box.
  localparam int CX_W = max_int(SIZE_W, $clog2(SCREEN_W + 1));
  localparam int CY_W = max_int(SIZE_W, $clog2(SCREEN_H + 1));
  localparam int SX_W = max_int(X_W, CX_W) + 1;
  localparam int SY_W = max_int(Y_W, CY_W) + 1;

  state_t              state;
  logic [1:0]          mode_q;
  logic [X_W-1:0]      ox_q;
  logic [Y_W-1:0]      oy_q;
  logic [COLOUR_W-1:0] col_q;

  logic            is_clear;
  logic            load;
  logic            advance;
  logic [CX_W-1:0] ld_w;
  logic [CY_W-1:0] ld_h;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic            last;
  logic            on_edge;
  logic [SX_W-1:0] sum_x;
  logic [SY_W-1:0] sum_y;
  logic            plot_ok;

  assign is_clear = (mode == MODE_CLEAR);
  assign load     = (state == ST_IDLE) && start;
  assign advance  = (state == ST_RUN);
  assign ld_w     = is_clear ? CX_W'(SCREEN_W) : CX_W'(w_in);
  assign ld_h     = is_clear ? CY_W'(SCREEN_H) : CY_W'(h_in);

  raster_scan #(
    .CX_W (CX_W),
    .CY_W (CY_W)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .width   (ld_w),
    .height  (ld_h),
    .advance (advance),
    .cx      (cx),
    .cy      (cy),
    .last    (last),
    .on_edge (on_edge)
  );

  // Sums carry one extra bit so off-screen clipping never sees a wrapped value.
  assign sum_x   = SX_W'(ox_q) + SX_W'(cx);
  assign sum_y   = SY_W'(oy_q) + SY_W'(cy);
  assign plot_ok = ((mode_q != MODE_OUTLINE) || on_edge)
                && (sum_x < SX_W'(SCREEN_W))
                && (sum_y < SY_W'(SCREEN_H));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      mode_q <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      col_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          plot <= 1'b0;
          if (start) begin
            mode_q <= (mode == 2'd3) ? MODE_FILLED : mode;
            ox_q   <= is_clear ? '0 : x_in;
            oy_q   <= is_clear ? '0 : y_in;
            col_q  <= colour_in;
            if (!is_clear && (w_in == '0 || h_in == '0))
              state <= ST_DONE;
            else
              state <= ST_RUN;
          end
        end
        ST_RUN: begin
          busy   <= 1'b1;
          plot   <= plot_ok;
          x      <= sum_x[X_W-1:0];
          y      <= sum_y[Y_W-1:0];
          colour <= col_q;
          if (last)
            state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          plot  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_plotter.sv
// Randomised and directed checks of box_plotter against a per-cycle
// expectation queue built from the rectangle/clip rules.
module tb_box_plotter;

  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [4:0] w_in;
  logic [4:0] h_in;
  logic [2:0] colour_in;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  always #10 clock = ~clock;

  box_plotter dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  typedef struct {
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t q[$];
  logic [7:0] hx = '0;
  logic [6:0] hy = '0;
  logic [2:0] hc = '0;
  int total = 0;
  int bad   = 0;
  int plot_x[$];
  int plot_y[$];
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_px(input string nm, input int i, input int ex, input int ey);
    int ax, ay;
    ax = (i < plot_x.size()) ? plot_x[i] : -1;
    ay = (i < plot_y.size()) ? plot_y[i] : -1;
    total++;
    if (ax != ex || ay != ey) begin
      bad++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", nm, ax, ay, ex, ey);
    end
  endtask

  // Expected outputs for every cycle after the accepting edge.
  task automatic push_cmd(input int m, input int xi, input int yi, input int wi,
                          input int hi, input logic [2:0] c);
    int ox, oy, ww, hh;
    bit pl;
    if (m == 2) begin
      ox = 0; oy = 0; ww = SW; hh = SH;
    end else begin
      ox = xi; oy = yi; ww = wi; hh = hi;
    end
    q.push_back('{1'b0, 1'b0, 1'b0, hx, hy, hc});
    for (int r = 0; r < hh; r++) begin
      for (int col = 0; col < ww; col++) begin
        pl = (m != 0 || col == 0 || col == ww - 1 || r == 0 || r == hh - 1)
             && (ox + col < SW) && (oy + r < SH);
        hx = 8'((ox + col) % 256);
        hy = 7'((oy + r) % 128);
        hc = c;
        q.push_back('{1'b1, 1'b0, pl, hx, hy, hc});
      end
    end
    q.push_back('{1'b0, 1'b1, 1'b0, hx, hy, hc});
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = '{1'b0, 1'b0, 1'b0, hx, hy, hc};
    total++;
    if ({busy, done, plot, x, y, colour} !== {e.busy, e.done, e.plot, e.x, e.y, e.c}) begin
      bad++;
      $display("FAIL cycle @%0t: busy/done/plot=%b%b%b x=%0d y=%0d c=%0d, expected %b%b%b x=%0d y=%0d c=%0d",
               $time, busy, done, plot, x, y, colour, e.busy, e.done, e.plot, e.x, e.y, e.c);
    end
    if (plot === 1'b1) begin
      plot_x.push_back(int'(x));
      plot_y.push_back(int'(y));
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic run_cmd(input int m, input int xi, input int yi, input int wi,
                         input int hi, input logic [2:0] c, input bit noise);
    bit fin;
    @(negedge clock);
    mode = 2'(m); x_in = 8'(xi); y_in = 7'(yi); w_in = 5'(wi); h_in = 5'(hi);
    colour_in = c; start = 1'b1;
    plot_x.delete(); plot_y.delete(); busy_cnt = 0; done_cnt = 0;
    @(posedge clock);
    push_cmd(m, xi, yi, wi, hi, c);
    #1;
    start = 1'b0;
    x_in = 8'($urandom); y_in = 7'($urandom); w_in = 5'($urandom);
    h_in = 5'($urandom); colour_in = 3'($urandom); mode = 2'($urandom);
    fin = 1'b0;
    for (int n = 0; n < 25000 && !fin; n++) begin
      @(posedge clock);
      if (q.size() == 0) begin
        fin = 1'b1;
      end else begin
        #1;
        // Only stir start while the next edge is still inside RUN/DONE.
        if (noise && q.size() >= 2 && $urandom_range(0, 3) == 0) begin
          start = 1'b1;
          mode = 2'($urandom); x_in = 8'($urandom); y_in = 7'($urandom);
          w_in = 5'($urandom); h_in = 5'($urandom); colour_in = 3'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (!fin) chk("cmd_timeout", 0, 1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int hits;
    reset = 1'b1; start = 1'b0; mode = '0; x_in = '0; y_in = '0;
    w_in = '0; h_in = '0; colour_in = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_xyc", int'({x, y, colour}), 0);
    reset = 1'b0;

    run_cmd(1, 10, 20, 2, 2, 3'b100, 1'b0);
    chk("fill2_plots", plot_x.size(), 4);
    chk_px("fill2_px0", 0, 10, 20);
    chk_px("fill2_px1", 1, 11, 20);
    chk_px("fill2_px2", 2, 10, 21);
    chk_px("fill2_px3", 3, 11, 21);
    chk("fill2_busy", busy_cnt, 4);
    chk("fill2_done", done_cnt, 1);

    run_cmd(0, 0, 0, 4, 4, 3'b010, 1'b0);
    chk("outline_busy", busy_cnt, 16);
    chk("outline_plots", plot_x.size(), 12);
    hits = 0;
    foreach (plot_x[i]) if (plot_x[i] inside {1, 2} && plot_y[i] inside {1, 2}) hits++;
    chk("outline_interior", hits, 0);

    run_cmd(1, 158, 118, 4, 4, 3'b111, 1'b0);
    chk("clip_busy", busy_cnt, 16);
    chk("clip_plots", plot_x.size(), 4);
    chk_px("clip_px0", 0, 158, 118);
    chk_px("clip_px1", 1, 159, 118);
    chk_px("clip_px2", 2, 158, 119);
    chk_px("clip_px3", 3, 159, 119);

    run_cmd(2, 50, 50, 3, 3, 3'b001, 1'b1);
    chk("clear_plots", plot_x.size(), SW * SH);
    chk("clear_busy", busy_cnt, SW * SH);
    chk_px("clear_first", 0, 0, 0);
    chk_px("clear_last", SW * SH - 1, 159, 119);
    chk("clear_done", done_cnt, 1);

    run_cmd(1, 7, 7, 0, 5, 3'b011, 1'b0);
    chk("zero_plots", plot_x.size(), 0);
    chk("zero_busy", busy_cnt, 0);
    chk("zero_done", done_cnt, 1);

    for (int i = 0; i < 25; i++) begin
      int m;
      m = $urandom_range(0, 3);
      if (m == 2) m = 3;
      run_cmd(m, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 31),
              $urandom_range(0, 31), 3'($urandom), 1'($urandom));
    end

    @(negedge clock);
    mode = 2'd1; x_in = 8'd5; y_in = 7'd5; w_in = 5'd16; h_in = 5'd16;
    colour_in = 3'd2; start = 1'b1;
    @(posedge clock);
    push_cmd(1, 5, 5, 16, 16, 3'd2);
    #1 start = 1'b0;
    repeat (40) @(posedge clock);
    #3;
    reset = 1'b1;
    q.delete();
    hx = '0; hy = '0; hc = '0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_cmd(1, 3, 3, 1, 1, 3'd7, 1'b0);
    chk("after_rst_plots", plot_x.size(), 1);
    chk_px("after_rst_px", 0, 3, 3);
    chk("after_rst_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/box_plotter.md
Name: box_plotter

Overview:
Parametrised pixel-sequencing engine that sits between game/control logic and vga_adapter. It accepts one command per handshake: draw a filled rectangle, draw an outlined rectangle, or clear the whole screen to a colour. It then emits one pixel write per clock as x, y, colour and plot. Command inputs are latched at acceptance, so callers may change them during drawing.

Parameters:
X_W, 8, width of x coordinate
Y_W, 7, width of y coordinate
COLOUR_W, 3, colour width (RGB, 1 bit per channel at default)
SIZE_W, 5, width of w_in/h_in; legal sizes 0..2**SIZE_W-1
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
start  in  1  command request; sampled only in IDLE
mode  in  2  0=OUTLINE, 1=FILLED, 2=CLEAR, 3=reserved (treated as FILLED)
x_in  in  X_W  rectangle top-left x
y_in  in  Y_W  rectangle top-left y
w_in  in  SIZE_W  rectangle width in pixels
h_in  in  SIZE_W  rectangle height in pixels
colour_in  in  COLOUR_W  draw colour (also used as the clear colour)
busy  out  1  high while a command is executing
done  out  1  one-cycle pulse after a command completes
x  out  X_W  pixel x to vga_adapter
y  out  Y_W  pixel y to vga_adapter
colour  out  COLOUR_W  pixel colour to vga_adapter
plot  out  1  write enable to vga_adapter

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, plot = 0; x, y, colour = 0; counters and latched command cleared. Reset mid-command aborts it: no further plots and no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge k, latch mode, x_in, y_in, w_in, h_in and colour_in, then go to RUN. For CLEAR, the latched origin becomes (0,0) and size becomes SCREEN_W x SCREEN_H. If latched w=0 or h=0 (non-CLEAR), go directly to DONE with no pixels.
- RUN: raster counter (cx, cy) starts at (0,0) and advances cx each cycle; when cx=w-1, cx wraps to 0 and cy increments. The last pixel is cx=w-1, cy=h-1. After the last pixel, go to DONE.
- Pixel N of the command (N=0..w*h-1) appears on the registered outputs in the cycle after edge k+1+N:
  - x = ox+cx, y = oy+cy, computed modulo 2**X_W and 2**Y_W;
  - colour = latched colour.
- plot = 1 only if all of the following hold:
  - the pixel is on the outline (cx=0 or cx=w-1 or cy=0 or cy=h-1) or mode is not OUTLINE;
  - ox+cx < SCREEN_W, evaluated with one extra bit so no wrap;
  - oy+cy < SCREEN_H, evaluated with one extra bit so no wrap.
  Otherwise plot=0, but the cycle is still spent. Latency is therefore exactly w*h cycles regardless of mode or clipping.
- busy = 1 in every cycle following edges k+1 .. k+w*h; 0 in IDLE and DONE.
- DONE: done=1 for exactly one cycle, plot=0, then return to IDLE. start is ignored in DONE and in RUN (no queuing). Earliest next acceptance is the cycle after done.
- Outputs x, y and colour hold their last values when plot=0 outside RUN.
- Total CLEAR duration is SCREEN_W*SCREEN_H cycles (19200 at defaults); the counter for CLEAR must be wide enough for SCREEN_W and SCREEN_H, independent of SIZE_W.

Decomposition:
- Shared package (vga_pkg):
  - mode constants MODE_OUTLINE, MODE_FILLED, MODE_CLEAR;
  - state encoding;
  - default SCREEN_W / SCREEN_H and coordinate widths.
- Sub-module raster_scan: 2-D counter.
  - Inputs: clock, reset, load, width, height, advance.
  - Outputs: cx, cy, last, edge (outline-pixel flag).
  - Parametrised on counter widths; reused later for sprite blitting.

Test Plan:
- FILLED, x_in=10, y_in=20, w=2, h=2, colour=3'b100 -> plots (10,20),(11,20),(10,21),(11,21) in 4 consecutive cycles with colour 100; done pulses one cycle after the last plot; busy high for exactly 4 cycles.
- OUTLINE, (0,0), w=4, h=4 -> 16 busy cycles; plot=1 on 12 border pixels; plot=0 at (1,1),(2,1),(1,2),(2,2).
- FILLED at (158,118), w=4, h=4 -> 16 busy cycles; plot=1 only at (158,118),(159,118),(158,119),(159,119).
- CLEAR, colour=3'b001 -> 19200 plots; first (0,0), last (159,119), all colour 001; done pulses afterwards; a start pulsed during busy produces no extra command.
- w=0, h=5 -> no plot, busy never high; done pulses in the second cycle after acceptance.
- Reset asserted mid-way through a 16x16 fill -> plot, busy and done drop to 0 immediately (asynchronously); after release, a fresh 1x1 command at (3,3) plots exactly (3,3).
